clk_div_sequencer: RTL

//  Programmable, glitch-free clock-divider controller. Generates clk_div as a

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_phase_cnt.sv | 67 ++++++
 rtl/clk_div_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_sequencer divided-clock controller.
// Optional rising-edge counter is enabled with the CLK_DIV_EDGE_CNT_EN macro.
package clk_div_pkg;

   localparam int CLK_DIV_HALF_W       = 8;
   localparam int CLK_DIV_DEFAULT_HALF = 3;
   localparam int CLK_DIV_EDGE_CNT_W   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } div_state_e;

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Half-period counter for clk_div_sequencer: counts while run is high, toggles
// clk_div every half cycles and flags the period boundary (the cycle before a fall).
module clk_div_phase_cnt
   import clk_div_pkg::*;
#(
   parameter int HALF_W = CLK_DIV_HALF_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [HALF_W-1:0] half,
   output logic              clk_div,
   output logic              rise,
   output logic              fall,
   output logic              boundary
);

   localparam logic [HALF_W-1:0] ONE = HALF_W'(1);

   logic [HALF_W-1:0] count_q, count_d;
   logic              clk_div_q, clk_div_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              terminal;

   assign terminal = (count_q == (half - ONE));

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      count_d   = count_q;
      clk_div_d = clk_div_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      if (!run) begin
         count_d   = '0;
         clk_div_d = 1'b0;
      end else if (terminal) begin
         count_d   = '0;
         clk_div_d = !clk_div_q;
         rise_d    = !clk_div_q;
         fall_d    = clk_div_q;
      end else begin
         count_d = count_q + ONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         clk_div_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         clk_div_q <= clk_div_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign clk_div  = clk_div_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign boundary = run && terminal && clk_div_q;

endmodule

// File: rtl/clk_div_sequencer.sv
// Glitch-free programmable clock divider controller: start/stop sequencing and
// ratio changes applied at full-period boundaries. Macro CLK_DIV_EDGE_CNT_EN adds edge_cnt.
module clk_div_sequencer
   import clk_div_pkg::*;
#(
   parameter int HALF_W       = CLK_DIV_HALF_W,
   parameter int DEFAULT_HALF = CLK_DIV_DEFAULT_HALF
`ifdef CLK_DIV_EDGE_CNT_EN
   ,
   parameter int EDGE_CNT_W   = CLK_DIV_EDGE_CNT_W
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  cfg_valid,
   input  logic [HALF_W-1:0]     cfg_half,
   output logic                  cfg_ready,
   output logic                  clk_div,
   output logic                  div_rise,
   output logic                  div_fall,
   output logic                  busy,
   output logic [HALF_W-1:0]     active_half
`ifdef CLK_DIV_EDGE_CNT_EN
   ,
   output logic [EDGE_CNT_W-1:0] edge_cnt
`endif
);

   div_state_e        state_q, state_d;
   logic              pend_q, pend_d;
   logic [HALF_W-1:0] pend_half_q, pend_half_d;
   logic [HALF_W-1:0] active_half_q, active_half_d;
   logic [HALF_W-1:0] next_half;
   logic              accept;
   logic              run;
   logic              boundary;

   assign accept    = cfg_valid && !pend_q;
   assign run       = (state_q == ST_RUN);
   // N that will be in force after this cycle if a pending change is applied now.
   assign next_half = pend_q ? pend_half_q : active_half_q;

   clk_div_phase_cnt #(
      .HALF_W (HALF_W)
   ) u_phase_cnt (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .half     (active_half_q),
      .clk_div  (clk_div),
      .rise     (div_rise),
      .fall     (div_fall),
      .boundary (boundary)
   );

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      pend_half_d   = pend_half_q;
      active_half_d = active_half_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               active_half_d = pend_half_q;
               pend_d        = 1'b0;
            end
            if (en && (next_half != '0)) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (boundary) begin
               if (pend_q) begin
                  active_half_d = pend_half_q;
                  pend_d        = 1'b0;
               end
               if (!en || (next_half == '0)) state_d = ST_STOP;
            end
         end
         ST_STOP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Acceptance needs pend clear and apply needs pend set, so they never collide.
      if (accept) begin
         pend_d      = 1'b1;
         pend_half_d = cfg_half;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pend_q        <= 1'b0;
         pend_half_q   <= '0;
         active_half_q <= HALF_W'(DEFAULT_HALF);
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         pend_half_q   <= pend_half_d;
         active_half_q <= active_half_d;
      end
   end

   assign cfg_ready   = !pend_q;
   assign busy        = (state_q != ST_IDLE);
   assign active_half = active_half_q;

`ifdef CLK_DIV_EDGE_CNT_EN
   logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;

   assign edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(div_rise);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) edge_cnt_q <= '0;
      else       edge_cnt_q <= edge_cnt_d;
   end

   assign edge_cnt = edge_cnt_q;
`endif

endmodule
